// File: rtl/division_unit_if.sv
// Handshake and operand bundle between the execute stage and the iterative divider.
// The master drives operands/start; the slave (divider) returns status and results.
interface division_unit_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] x1;
   logic [WIDTH-1:0] x2;
   logic [WIDTH-1:0] fwd;
   logic             forwardA;
   logic             forwardB;
   logic             is_signed;
   logic             start;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output x1, x2, fwd, forwardA, forwardB, is_signed, start,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  x1, x2, fwd, forwardA, forwardB, is_signed, start,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/division_unit.sv
// Radix-2 restoring divider: signed/unsigned quotient and remainder in 32 iterations,
// with a one-cycle path for a zero divisor.
module division_unit #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset,
   division_unit_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] dividend_sel, divisor_sel;
   logic [WIDTH-1:0] abs_dividend, abs_divisor;
   logic             divisor_zero;
   logic [WIDTH-1:0] quo_reg, rem_reg, divisor_reg;
   logic [CNT_W-1:0] count_reg;
   logic             neg_q_reg, neg_r_reg, dbz_reg;
   logic [WIDTH:0]   shifted;
   logic             trial_ok;
   logic [WIDTH-1:0] trial_diff;
   logic [WIDTH-1:0] quotient_reg, remainder_reg;
   logic             div_by_zero_reg, done_reg;

   // forwardA wins when both forward flags are raised
   always_comb begin
      dividend_sel = bus.forwardA ? bus.fwd : bus.x1;
      divisor_sel  = (!bus.forwardA && bus.forwardB) ? bus.fwd : bus.x2;
      divisor_zero = (divisor_sel == '0);
      abs_dividend = (bus.is_signed && dividend_sel[WIDTH-1]) ? -dividend_sel : dividend_sel;
      abs_divisor  = (bus.is_signed && divisor_sel[WIDTH-1])  ? -divisor_sel  : divisor_sel;
   end

   // The shifted remainder can exceed 32 bits, so the trial compare is done at 33 bits;
   // whenever it succeeds the true difference fits in 32 bits.
   always_comb begin
      shifted    = {rem_reg, quo_reg[WIDTH-1]};
      trial_ok   = (shifted >= {1'b0, divisor_reg});
      trial_diff = shifted[WIDTH-1:0] - divisor_reg;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.start) state_next = divisor_zero ? FINISH : RUN;
         RUN:     if (count_reg == CNT_W'(WIDTH - 1)) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quo_reg         <= '0;
         rem_reg         <= '0;
         divisor_reg     <= '0;
         count_reg       <= '0;
         neg_q_reg       <= 1'b0;
         neg_r_reg       <= 1'b0;
         dbz_reg         <= 1'b0;
         quotient_reg    <= '0;
         remainder_reg   <= '0;
         div_by_zero_reg <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  neg_q_reg   <= bus.is_signed & (dividend_sel[WIDTH-1] ^ divisor_sel[WIDTH-1]);
                  neg_r_reg   <= bus.is_signed & dividend_sel[WIDTH-1];
                  dbz_reg     <= divisor_zero;
                  divisor_reg <= abs_divisor;
                  rem_reg     <= '0;
                  count_reg   <= '0;
                  // a zero divisor skips RUN, so keep the raw dividend for the remainder
                  quo_reg     <= divisor_zero ? dividend_sel : abs_dividend;
               end
            end
            RUN: begin
               count_reg <= count_reg + 1'b1;
               quo_reg   <= {quo_reg[WIDTH-2:0], trial_ok};
               rem_reg   <= trial_ok ? trial_diff : shifted[WIDTH-1:0];
            end
            FINISH: begin
               done_reg        <= 1'b1;
               div_by_zero_reg <= dbz_reg;
               if (dbz_reg) begin
                  quotient_reg  <= '1;
                  remainder_reg <= quo_reg;
               end else begin
                  quotient_reg  <= neg_q_reg ? -quo_reg : quo_reg;
                  remainder_reg <= neg_r_reg ? -rem_reg : rem_reg;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.busy        = (state_reg != IDLE);
      bus.done        = done_reg;
      bus.quotient    = quotient_reg;
      bus.remainder   = remainder_reg;
      bus.div_by_zero = div_by_zero_reg;
   end
endmodule

// File: tb/tb_division_unit.sv
// Directed self-checking bench for division_unit: arithmetic, forwarding, divide-by-zero,
// latency and handshake/reset behaviour against hand-computed expectations.
module tb_division_unit;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   lat, bc, seen;

   division_unit_if #(.WIDTH(32)) bus ();

   division_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // called at a negedge; start is sampled at the next posedge (E0), returns after E0
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] f,
                           input logic fa, input logic fb, input logic sg);
      bus.x1 = a; bus.x2 = b; bus.fwd = f;
      bus.forwardA = fa; bus.forwardB = fb; bus.is_signed = sg;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.x1 = $urandom; bus.x2 = $urandom; bus.fwd = $urandom;
      bus.forwardA = 1'b0; bus.forwardB = 1'b0; bus.is_signed = 1'b0;
   endtask

   // lat = clock edges after E0 until done is seen; bc = cycles with busy high
   task automatic wait_done(output int l, output int b);
      l = 0; b = 0;
      while (bus.done !== 1'b1 && l < 100) begin
         if (bus.busy === 1'b1) b++;
         @(negedge clk);
         l++;
      end
   endtask

   task automatic div_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] f, input logic fa, input logic fb, input logic sg,
                            input logic [31:0] eq, input logic [31:0] er, input logic ez,
                            input int elat);
      int l, bcnt;
      start_op(a, b, f, fa, fb, sg);
      wait_done(l, bcnt);
      chk({tag, "_q"}, bus.quotient, eq);
      chk({tag, "_r"}, bus.remainder, er);
      chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
      chk({tag, "_lat"}, 32'(l), 32'(elat));
      chk({tag, "_busy"}, 32'(bcnt), 32'(elat));
      $display("txn %s a=0x%08h b=0x%08h f=0x%08h fa=%0b fb=%0b s=%0b q=0x%08h r=0x%08h dbz=%0b lat=%0d",
               tag, a, b, f, fa, fb, sg, bus.quotient, bus.remainder, bus.div_by_zero, l);
   endtask

   initial begin
      bus.x1 = '0; bus.x2 = '0; bus.fwd = '0;
      bus.forwardA = 1'b0; bus.forwardB = 1'b0; bus.is_signed = 1'b0; bus.start = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_q", bus.quotient, 32'd0);
      chk("rst_r", bus.remainder, 32'd0);
      chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      div_check("udiv",      32'd100,        32'd7,          32'd0,  0, 0, 0, 32'd14,         32'd2,          0, 33);
      div_check("sdiv_nn",   32'hFFFF_FFF9,  32'd2,          32'd0,  0, 0, 1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  0, 33);
      div_check("sdiv_pn",   32'd7,          32'hFFFF_FFFE,  32'd0,  0, 0, 1, 32'hFFFF_FFFD,  32'd1,          0, 33);
      div_check("udiv_big",  32'hFFFF_FFF9,  32'd2,          32'd0,  0, 0, 0, 32'h7FFF_FFFC,  32'd1,          0, 33);
      div_check("udiv_msb",  32'hFFFF_FFFF,  32'h8000_0001,  32'd0,  0, 0, 0, 32'd1,          32'h7FFF_FFFE,  0, 33);
      div_check("dbz",       32'h1234_5678,  32'd0,          32'd0,  0, 0, 0, 32'hFFFF_FFFF,  32'h1234_5678,  1, 1);
      div_check("ovf",       32'h8000_0000,  32'hFFFF_FFFF,  32'd0,  0, 0, 1, 32'h8000_0000,  32'd0,          0, 33);
      div_check("sdbz",      32'hFFFF_FFF9,  32'd0,          32'd0,  0, 0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1, 1);
      div_check("fwd_a",     32'd9,          32'd4,          32'd30, 1, 0, 0, 32'd7,          32'd2,          0, 33);
      div_check("fwd_b",     32'd9,          32'd4,          32'd30, 0, 1, 0, 32'd0,          32'd9,          0, 33);
      div_check("fwd_ab",    32'd9,          32'd4,          32'd30, 1, 1, 0, 32'd7,          32'd2,          0, 33);

      // start pulse mid-run must be ignored
      start_op(32'd100, 32'd7, 32'd0, 0, 0, 0);
      repeat (5) @(negedge clk);
      bus.x1 = 32'd1000; bus.x2 = 32'd3; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(lat, bc);
      chk("ign_lat", 32'(lat), 32'd27);
      chk("ign_q", bus.quotient, 32'd14);
      chk("ign_r", bus.remainder, 32'd2);
      $display("txn ign_start q=0x%08h r=0x%08h lat=%0d", bus.quotient, bus.remainder, lat);

      // back-to-back: new start in the done cycle
      start_op(32'd200, 32'd9, 32'd0, 0, 0, 0);
      wait_done(lat, bc);
      chk("b2b1_done", 32'(bus.done), 32'd1);
      chk("b2b1_q", bus.quotient, 32'd22);
      chk("b2b1_r", bus.remainder, 32'd2);
      $display("txn b2b_first q=0x%08h r=0x%08h lat=%0d", bus.quotient, bus.remainder, lat);
      start_op(32'd50, 32'd6, 32'd0, 0, 0, 0);
      chk("b2b_done_low", 32'(bus.done), 32'd0);
      chk("b2b_busy", 32'(bus.busy), 32'd1);
      chk("b2b_hold_q", bus.quotient, 32'd22);
      wait_done(lat, bc);
      chk("b2b2_lat", 32'(lat), 32'd33);
      chk("b2b2_q", bus.quotient, 32'd8);
      chk("b2b2_r", bus.remainder, 32'd2);
      $display("txn b2b_second q=0x%08h r=0x%08h lat=%0d", bus.quotient, bus.remainder, lat);

      // reset at cycle 10 of a run
      @(negedge clk);
      start_op(32'd1000, 32'd3, 32'd0, 0, 0, 0);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_done", 32'(bus.done), 32'd0);
      chk("mid_rst_q", bus.quotient, 32'd0);
      chk("mid_rst_r", bus.remainder, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      end
      chk("mid_rst_quiet", 32'(seen), 32'd0);
      $display("txn mid_reset busy=%0b done=%0b q=0x%08h r=0x%08h", bus.busy, bus.done,
               bus.quotient, bus.remainder);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
